mc_control_fsm: RTL and testbench

- Multi-cycle successor to the single-cycle main decoder.
- Sequences each MIPS instruction (R-type, lw, sw, beq, bne, addi, j) through fetch/decode/execute/memory/writeback states.
- Drives the shared-ALU multi-cycle datapath and handshakes with a variable-latency unified memory.
- Adds illegal-opcode detection and a memory-wait timeout.

---
 rtl/mc_control_fsm.sv | 224 ++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS control FSM with memory-wait timeout
// Optional performance counters are enabled by defining MC_CONTROL_PERF_EN.
module mc_control_fsm #(
  parameter int OPW         = 6,
  parameter int ALUOP_W     = 2,
  parameter int CNT_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPW-1:0]     opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_write_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic [3:0]         state,
`ifdef MC_CONTROL_PERF_EN
  output logic [31:0]        cycle_count,
  output logic [31:0]        instr_count,
`endif
  output logic               illegal_op,
  output logic               mem_timeout
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  logic [3:0]       next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             timeout_hit;
  logic             illegal_dec;
  logic [1:0]       aop;

  assign in_wait     = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // A ready memory in the deadline cycle completes normally instead of aborting.
  assign timeout_hit = (MEM_TIMEOUT != 0) && in_wait && !mem_ready && (wait_cnt == TIMEOUT_VAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if ((next_state != state) || timeout_hit)
        wait_cnt <= '0;
      else if (in_wait && !mem_ready && (wait_cnt != {CNT_W{1'b1}}))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state  = S_FETCH;
    illegal_dec = 1'b0;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      next_state = S_EXEC;
          OP_LW, OP_SW:  next_state = S_MEMADR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_ADDI:       next_state = S_ADDIEX;
          OP_J:          next_state = S_JUMP;
          default: begin
            next_state  = S_FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_ADDIEX: next_state = S_ADDIWB;
      S_ADDIWB: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
    if (timeout_hit)
      next_state = S_FETCH;
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_write_ne   = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aop           = 2'b00;
    pc_src        = 2'b00;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = illegal_dec;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        aop       = 2'b10;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aop           = 2'b01;
        pc_src        = 2'b01;
        pc_write_cond = (opcode == OP_BEQ);
        pc_write_ne   = (opcode == OP_BNE);
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aop       = 2'b11;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    mem_timeout = timeout_hit;
    alu_op      = ALUOP_W'(aop);
    // Reset abandons the instruction: no strobe may escape while it is held.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_write_ne   = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = '0;
      pc_src        = 2'b00;
      illegal_op    = 1'b0;
      mem_timeout   = 1'b0;
    end
  end

`ifdef MC_CONTROL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if ((next_state == S_FETCH) && (state != S_FETCH) && !illegal_dec && !timeout_hit)
        instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed scoreboard bench for mc_control_fsm
// Control vector order: pw pwc pwne iord mr mw irw rdst mtr rw asa asb aop psrc ill to
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_write_ne, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op, mem_timeout;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
`ifdef MC_CONTROL_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  always #5 clk = ~clk;

  mc_control_fsm #(.OPW(6), .ALUOP_W(2), .CNT_W(8), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_ne(pc_write_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state(state),
`ifdef MC_CONTROL_PERF_EN
    .cycle_count(cycle_count), .instr_count(instr_count),
`endif
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  localparam logic [18:0] C_FETCH_R = 19'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] C_FETCH_N = 19'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] C_FETCH_T = 19'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0_1;
  localparam logic [18:0] C_DECODE  = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [18:0] C_DEC_ILL = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam logic [18:0] C_MEMADR  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [18:0] C_MEMRD   = 19'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] C_MEMWB   = 19'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
  localparam logic [18:0] C_MEMWR   = 19'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] C_EXEC    = 19'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [18:0] C_ALUWB   = 19'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [18:0] C_BEQ     = 19'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [18:0] C_BNE     = 19'b0_0_1_0_0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [18:0] C_ADDIEX  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_11_00_0_0;
  localparam logic [18:0] C_ADDIWB  = 19'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0_0;
  localparam logic [18:0] C_JUMP    = 19'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0_0;
  localparam logic [18:0] C_ZERO    = 19'b0;

  typedef struct packed {
    logic [3:0]  st;
    logic [18:0] ctrl;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [18:0] obs;

  assign obs = {pc_write, pc_write_cond, pc_write_ne, iord, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                illegal_op, mem_timeout};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // One clock cycle: drive inputs, push expectation, compare at the falling edge.
  task automatic step(input string tag, input logic rst, input logic [5:0] op, input logic mr,
                      input logic [3:0] est, input logic [18:0] ectrl);
    exp_t e;
    reset     = rst;
    opcode    = op;
    mem_ready = mr;
    q.push_back('{st: est, ctrl: ectrl});
    @(negedge clk);
    e = q.pop_front();
    check({tag, ".state"}, 32'(state), 32'(e.st));
    check({tag, ".ctrl"},  32'(obs),   32'(e.ctrl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    step("reset", 1'b1, 6'b000000, 1'b1, 4'd0, C_ZERO);

    step("addi1.f",  1'b0, 6'b001000, 1'b1, 4'd0,  C_FETCH_R);
    step("addi1.d",  1'b0, 6'b001000, 1'b1, 4'd1,  C_DECODE);
    step("addi1.ex", 1'b0, 6'b001000, 1'b1, 4'd9,  C_ADDIEX);
    step("addi1.wb", 1'b0, 6'b001000, 1'b1, 4'd10, C_ADDIWB);
    step("addi2.f",  1'b0, 6'b001000, 1'b1, 4'd0,  C_FETCH_R);
    step("addi2.d",  1'b0, 6'b001000, 1'b1, 4'd1,  C_DECODE);
    step("addi2.ex", 1'b0, 6'b001000, 1'b1, 4'd9,  C_ADDIEX);
    step("addi2.wb", 1'b0, 6'b001000, 1'b1, 4'd10, C_ADDIWB);
`ifdef MC_CONTROL_PERF_EN
    @(negedge clk);
    check("perf.cycle", cycle_count, 32'd8);
    check("perf.instr", instr_count, 32'd2);
    @(posedge clk); #1;
`endif

    step("lw.f",   1'b0, 6'b100011, 1'b1, 4'd0, C_FETCH_R);
    step("lw.d",   1'b0, 6'b100011, 1'b1, 4'd1, C_DECODE);
    step("lw.adr", 1'b0, 6'b100011, 1'b1, 4'd2, C_MEMADR);
    step("lw.rd",  1'b0, 6'b100011, 1'b1, 4'd3, C_MEMRD);
    step("lw.wb",  1'b0, 6'b100011, 1'b1, 4'd4, C_MEMWB);

    step("r.f",   1'b0, 6'b000000, 1'b1, 4'd0, C_FETCH_R);
    step("r.d",   1'b0, 6'b000000, 1'b1, 4'd1, C_DECODE);
    step("r.ex",  1'b0, 6'b000000, 1'b1, 4'd6, C_EXEC);
    step("r.wb",  1'b0, 6'b000000, 1'b1, 4'd7, C_ALUWB);
    step("j.f",   1'b0, 6'b000010, 1'b1, 4'd0, C_FETCH_R);
    step("j.d",   1'b0, 6'b000010, 1'b1, 4'd1, C_DECODE);
    step("j.j",   1'b0, 6'b000010, 1'b1, 4'd11, C_JUMP);

    step("beq.f", 1'b0, 6'b000100, 1'b1, 4'd0, C_FETCH_R);
    step("beq.d", 1'b0, 6'b000100, 1'b1, 4'd1, C_DECODE);
    step("beq.b", 1'b0, 6'b000100, 1'b1, 4'd8, C_BEQ);
    step("bne.f", 1'b0, 6'b000101, 1'b1, 4'd0, C_FETCH_R);
    step("bne.d", 1'b0, 6'b000101, 1'b1, 4'd1, C_DECODE);
    step("bne.b", 1'b0, 6'b000101, 1'b1, 4'd8, C_BNE);

    step("sw.f",   1'b0, 6'b101011, 1'b1, 4'd0, C_FETCH_R);
    step("sw.d",   1'b0, 6'b101011, 1'b1, 4'd1, C_DECODE);
    step("sw.adr", 1'b0, 6'b101011, 1'b1, 4'd2, C_MEMADR);
    for (int i = 0; i < 3; i++)
      step("sw.wait", 1'b0, 6'b101011, 1'b0, 4'd5, C_MEMWR);
    step("sw.done", 1'b0, 6'b101011, 1'b1, 4'd5, C_MEMWR);

    for (int i = 0; i < 4; i++)
      step("to.wait", 1'b0, 6'b000000, 1'b0, 4'd0, C_FETCH_N);
    step("to.abort", 1'b0, 6'b000000, 1'b0, 4'd0, C_FETCH_T);
    step("to.clear", 1'b0, 6'b000000, 1'b0, 4'd0, C_FETCH_N);

    step("ill.f", 1'b0, 6'b111111, 1'b1, 4'd0, C_FETCH_R);
    step("ill.d", 1'b0, 6'b111111, 1'b1, 4'd1, C_DEC_ILL);

    step("rst.f",   1'b0, 6'b100011, 1'b1, 4'd0, C_FETCH_R);
    step("rst.d",   1'b0, 6'b100011, 1'b1, 4'd1, C_DECODE);
    step("rst.adr", 1'b0, 6'b100011, 1'b1, 4'd2, C_MEMADR);
    step("rst.rd",  1'b0, 6'b100011, 1'b0, 4'd3, C_MEMRD);
    step("rst.hold", 1'b1, 6'b100011, 1'b1, 4'd3, C_ZERO);
    step("rst.st0",  1'b1, 6'b100011, 1'b1, 4'd0, C_ZERO);
    step("rst.rel",  1'b0, 6'b000000, 1'b1, 4'd0, C_FETCH_R);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
